brom_overlay: RTL and testbench

//  CPU-side bus stage directly upstream of the 256-byte boot ROM array. Decodes each
//  CPU access: 0x0000-0x00FF reads go to the boot ROM while the overlay is active;

---
 rtl/gb_bus_pkg.sv | 22 ++
 rtl/brom_overlay.sv | 136 +++++++++++++
 tb/tb_brom_overlay.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gb_bus_pkg.sv
// Shared definitions for the CPU-side bus stage in front of the boot ROM:
// state encoding, ROM window, lock register default address and open-bus value.
package gb_bus_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BROM_RD  = 2'd1;
  localparam logic [1:0] ST_EXT_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_BROM_RD  = ST_BROM_RD,
    S_EXT_WAIT = ST_EXT_WAIT,
    S_RESP     = ST_RESP
  } bus_state_e;

  localparam logic [15:0] BROM_BASE     = 16'h0000;
  localparam logic [15:0] BROM_LAST     = 16'h00FF;
  localparam logic [15:0] LOCK_ADDR_DEF = 16'hFF50;
  localparam logic [7:0]  OPEN_BUS      = 8'hFF;

endpackage

// File: rtl/brom_overlay.sv
// CPU bus stage in front of the 256-byte boot ROM: decodes accesses between the
// ROM overlay, the sticky boot-lock register and the external bus (wait states, timeout).
module brom_overlay
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] LOCK_ADDR   = LOCK_ADDR_DEF,
  parameter int unsigned EXT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  brom_a,
  input  logic [7:0]  brom_d,
  output logic [15:0] ext_a,
  output logic [7:0]  ext_dout,
  output logic        ext_rd,
  output logic        ext_wr,
  input  logic [7:0]  ext_din,
  input  logic        ext_ack,
  output logic        boot_done
);

  bus_state_e  state_q, state_d;
  logic [7:0]  brom_a_q, brom_a_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic [15:0] ext_a_q, ext_a_d;
  logic [7:0]  ext_dout_q, ext_dout_d;
  logic        ext_rd_q, ext_rd_d;
  logic        ext_wr_q, ext_wr_d;
  logic        boot_done_q, boot_done_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [8:0]  cnt_inc;
  logic        timeout;
  logic        in_brom;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign timeout = (cnt_inc == 9'(EXT_TIMEOUT));
  assign in_brom = (cpu_a[15:8] == BROM_BASE[15:8]);

  always_comb begin
    state_d     = state_q;
    brom_a_d    = brom_a_q;
    cpu_din_d   = cpu_din_q;
    ext_a_d     = ext_a_q;
    ext_dout_d  = ext_dout_q;
    ext_rd_d    = ext_rd_q;
    ext_wr_d    = ext_wr_q;
    boot_done_d = boot_done_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (!cpu_we && !boot_done_q && in_brom) begin
            brom_a_d = cpu_a[7:0];
            state_d  = S_BROM_RD;
          end else if (cpu_a == LOCK_ADDR) begin
            // Lock register is local; a zero write leaves the overlay untouched.
            if (cpu_we && (cpu_dout != 8'h00)) boot_done_d = 1'b1;
            cpu_din_d = OPEN_BUS;
            state_d   = S_RESP;
          end else begin
            ext_a_d    = cpu_a;
            ext_dout_d = cpu_dout;
            ext_rd_d   = !cpu_we;
            ext_wr_d   = cpu_we;
            state_d    = S_EXT_WAIT;
          end
        end
      end
      S_BROM_RD: begin
        cpu_din_d = brom_d;
        state_d   = S_RESP;
      end
      S_EXT_WAIT: begin
        cnt_d = cnt_inc[7:0];
        // An ack landing on the timeout cycle still delivers its data.
        if (ext_ack) begin
          if (ext_rd_q) cpu_din_d = ext_din;
          ext_rd_d = 1'b0;
          ext_wr_d = 1'b0;
          state_d  = S_RESP;
        end else if (timeout) begin
          if (ext_rd_q) cpu_din_d = OPEN_BUS;
          ext_rd_d = 1'b0;
          ext_wr_d = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      brom_a_q    <= 8'h00;
      cpu_din_q   <= OPEN_BUS;
      ext_a_q     <= 16'h0000;
      ext_dout_q  <= 8'h00;
      ext_rd_q    <= 1'b0;
      ext_wr_q    <= 1'b0;
      boot_done_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      brom_a_q    <= brom_a_d;
      cpu_din_q   <= cpu_din_d;
      ext_a_q     <= ext_a_d;
      ext_dout_q  <= ext_dout_d;
      ext_rd_q    <= ext_rd_d;
      ext_wr_q    <= ext_wr_d;
      boot_done_q <= boot_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_ack   = (state_q == S_RESP);
  assign cpu_din   = cpu_din_q;
  assign brom_a    = brom_a_q;
  assign ext_a     = ext_a_q;
  assign ext_dout  = ext_dout_q;
  assign ext_rd    = ext_rd_q;
  assign ext_wr    = ext_wr_q;
  assign boot_done = boot_done_q;

endmodule

// File: tb/tb_brom_overlay.sv
// Randomized bench for brom_overlay: ROM and external-bus responders plus an
// access-level reference model of routing, latency, strobes, read data and lock.
module tb_brom_overlay;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [7:0]  brom_a;
  logic [7:0]  brom_d;
  logic [15:0] ext_a;
  logic [7:0]  ext_dout;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_din;
  logic        ext_ack;
  logic        boot_done;

  brom_overlay dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .brom_a(brom_a), .brom_d(brom_d),
    .ext_a(ext_a), .ext_dout(ext_dout), .ext_rd(ext_rd), .ext_wr(ext_wr),
    .ext_din(ext_din), .ext_ack(ext_ack),
    .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  assign brom_d = rom[brom_a];

  int         ext_lat = 0;
  logic [7:0] ext_data = 8'h00;

  int checks = 0;
  int failures = 0;

  logic       m_bd = 1'b0;
  logic [7:0] m_din = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // External device: acks after ext_lat strobe cycles (0 = never).
  initial begin
    int hi;
    hi = 0;
    ext_ack = 1'b0;
    ext_din = 8'h00;
    forever begin
      @(negedge clk);
      if (ext_rd || ext_wr) begin
        hi++;
        ext_ack = (ext_lat != 0) && (hi == ext_lat);
        ext_din = ext_data;
      end else begin
        hi = 0;
        ext_ack = 1'b0;
      end
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    m_bd = 1'b0;
    m_din = 8'hFF;
    chk({tag, ".din"}, 32'(cpu_din), 32'hFF);
    chk({tag, ".ack"}, 32'(cpu_ack), 32'h0);
    chk({tag, ".brom_a"}, 32'(brom_a), 32'h0);
    chk({tag, ".ext_a"}, 32'(ext_a), 32'h0);
    chk({tag, ".ext_dout"}, 32'(ext_dout), 32'h0);
    chk({tag, ".strobes"}, 32'({ext_rd, ext_wr}), 32'h0);
    chk({tag, ".boot_done"}, 32'(boot_done), 32'h0);
  endtask

  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                        input int lat, input logic [7:0] xd, input string tag);
    bit is_rom, is_lock, is_ext, acked, done;
    int exp_lat, exp_rd, exp_wr, cyc, rdc, wrc, both, got_lat;
    logic [15:0] seen_a;
    logic [7:0]  seen_d, got_din;
    is_rom  = !we && !m_bd && (a < 16'h0100);
    is_lock = !is_rom && (a == 16'hFF50);
    is_ext  = !is_rom && !is_lock;
    acked   = (lat >= 1) && (lat <= TO);
    exp_rd  = 0;
    exp_wr  = 0;
    if (is_rom) begin
      exp_lat = 2;
      m_din = rom[a[7:0]];
    end else if (is_lock) begin
      exp_lat = 1;
      m_din = 8'hFF;
      if (we && d != 8'h00) m_bd = 1'b1;
    end else begin
      exp_lat = acked ? lat + 1 : TO + 1;
      if (we) exp_wr = acked ? lat : TO;
      else begin
        exp_rd = acked ? lat : TO;
        m_din = acked ? xd : 8'hFF;
      end
    end
    ext_lat = lat;
    ext_data = xd;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_dout = d;
    cyc = 0; rdc = 0; wrc = 0; both = 0; done = 0; got_lat = -1;
    seen_a = 16'hDEAD; seen_d = 8'h5A; got_din = 8'h00;
    while (!done && cyc < 64) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ext_rd) rdc++;
      if (ext_wr) wrc++;
      if (ext_rd && ext_wr) both++;
      if (ext_rd || ext_wr) begin
        seen_a = ext_a;
        seen_d = ext_dout;
      end
      if (cpu_ack) begin
        done = 1;
        got_lat = cyc;
        got_din = cpu_din;
      end
    end
    @(posedge clk);
    #1 cpu_req = 1'b0;
    chk({tag, ".lat"}, 32'(got_lat), 32'(exp_lat));
    chk({tag, ".rd_cycles"}, 32'(rdc), 32'(exp_rd));
    chk({tag, ".wr_cycles"}, 32'(wrc), 32'(exp_wr));
    chk({tag, ".excl"}, 32'(both), 32'h0);
    if (!we) chk({tag, ".din"}, 32'(got_din), 32'(m_din));
    if (is_rom) chk({tag, ".brom_a"}, 32'(brom_a), 32'(a[7:0]));
    if (is_ext) chk({tag, ".ext_a"}, 32'(seen_a), 32'(a));
    if (is_ext && we) chk({tag, ".ext_dout"}, 32'(seen_d), 32'(d));
    @(negedge clk);
    chk({tag, ".ack_once"}, 32'(cpu_ack), 32'h0);
    chk({tag, ".boot_done"}, 32'(boot_done), 32'(m_bd));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h31;

    do_reset("rst0");

    access(1'b0, 16'h0000, 8'h00, 0, 8'h00, "t1_rom0");
    access(1'b0, 16'h0150, 8'h00, 3, 8'hC3, "t2_ext");
    access(1'b1, 16'h2000, 8'h01, 2, 8'h00, "t5_wr2000");
    access(1'b1, 16'h0010, 8'h0A, 1, 8'h00, "t5_wr0010");
    access(1'b0, 16'hFF50, 8'h00, 0, 8'h00, "t5_rdlock");
    access(1'b1, 16'hFF50, 8'h00, 1, 8'h00, "t3_lock0");
    access(1'b0, 16'h00FF, 8'h00, 0, 8'h00, "t3_romlast");
    access(1'b1, 16'hFF50, 8'h01, 1, 8'h00, "t3_lock1");
    access(1'b0, 16'h0000, 8'h00, 2, 8'h77, "t3_ext0000");
    access(1'b0, 16'h8000, 8'h00, 0, 8'h12, "t4_timeout");
    access(1'b0, 16'h4000, 8'h00, TO, 8'h9C, "t4_ack_at_to");

    // Reset in the middle of an unacknowledged external read.
    ext_lat = 0;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 16'h8000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_rd", 32'(ext_rd), 32'h1);
    chk("t6_pre_bd", 32'(boot_done), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_drop", 32'(ext_rd), 32'h0);
    chk("t6_bd_clear", 32'(boot_done), 32'h0);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_ack", 32'(cpu_ack), 32'h0);
    end
    #1 rst_n = 1'b1;
    m_bd = 1'b0;
    m_din = 8'hFF;
    access(1'b0, 16'h0000, 8'h00, 0, 8'h00, "t6_rom0");

    for (int n = 0; n < 60; n++) begin
      int sel, lat;
      logic we;
      logic [15:0] a;
      logic [7:0] d;
      if (n % 15 == 14) do_reset("rnd_rst");
      sel = $urandom_range(0, 3);
      we  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      lat = $urandom_range(0, 17);
      case (sel)
        0: a = {8'h00, 8'($urandom)};
        1: begin
          a = 16'hFF50;
          if ($urandom_range(0, 1) == 1) d = 8'h00;
        end
        2: a = 16'($urandom);
        default: a = {1'b1, 15'($urandom)};
      endcase
      access(we, a, d, lat, 8'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
